// File: rtl/ip_codma_wr_data_buffer.sv
// Ping-pong staging buffer between the CODMA read and write machines; drains 8x32 bursts as 64-bit beats.
// Define CODMA_WRBUF_BSWAP_EN to byte-reverse every 32-bit word on capture.
module ip_codma_wr_data_buffer #(
    parameter int NUM_BANKS = 2,
    parameter int BEAT_W    = 64
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              stop_i,
    input  logic              load_i,
    input  logic [3:0]        size_i,
    input  logic [255:0]      data_i,
    output logic [BEAT_W-1:0] wr_data_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic              wr_last_o,
    output logic [3:0]        wr_size_o,
    output logic [7:0]        wr_word_count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              size_err_o,
    output logic              ovf_err_o
);

    localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(NUM_BANKS);

    typedef enum logic [1:0] {
        BUF_IDLE,
        BUF_DRAIN,
        BUF_LAST
    } bufState_t;

    function automatic logic [2:0] beatsOf(input logic [3:0] size);
        case (size)
            4'd9:    beatsOf = 3'd4;
            4'd8:    beatsOf = 3'd2;
            4'd3:    beatsOf = 3'd1;
            default: beatsOf = 3'd0;
        endcase
    endfunction

    function automatic logic [255:0] captureData(input logic [255:0] d);
        logic [255:0] r;
`ifdef CODMA_WRBUF_BSWAP_EN
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 4; b++) begin
                r[32*w + 8*b +: 8] = d[32*w + 8*(3-b) +: 8];
            end
        end
`else
        r = d;
`endif
        return r;
    endfunction

    bufState_t          r_state;
    logic [255:0]       r_bankData [NUM_BANKS];
    logic [3:0]         r_bankSize [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_bankValid;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W:0]     r_count;
    logic [1:0]         r_beatIdx;
    logic [1:0]         r_lastIdx;

    logic               w_handshake;
    logic               w_finalAccept;
    logic [2:0]         w_loadBeats;
    logic               w_loadLegal;
    logic               w_loadAccept;
    logic               w_loadOvf;
    logic [255:0]       w_loadData;
    logic               w_srcValid;
    logic [255:0]       w_srcData;
    logic [3:0]         w_srcSize;
    logic [2:0]         w_srcBeats;
    logic [1:0]         w_srcLastIdx;
    logic [1:0]         w_nextIdx;
    logic [PTR_W:0]     w_countNext;
    logic [NUM_BANKS-1:0] w_bankValidNext;

    assign w_handshake   = wr_valid_o && wr_ready_i;
    assign w_finalAccept = (r_state == BUF_LAST) && w_handshake;
    assign w_loadBeats   = beatsOf(size_i);
    assign w_loadLegal   = |w_loadBeats;
    // A bank whose final beat is accepting this cycle is free for the incoming burst.
    assign w_loadAccept  = load_i && w_loadLegal && (!full_o || w_finalAccept);
    assign w_loadOvf     = load_i && w_loadLegal && full_o && !w_finalAccept;
    assign w_loadData    = captureData(data_i);

    // An empty buffer starts draining straight from the incoming load to get one-cycle latency.
    assign w_srcValid    = r_bankValid[r_rdPtr] || (w_loadAccept && (r_wrPtr == r_rdPtr));
    assign w_srcData     = r_bankValid[r_rdPtr] ? r_bankData[r_rdPtr] : w_loadData;
    assign w_srcSize     = r_bankValid[r_rdPtr] ? r_bankSize[r_rdPtr] : size_i;
    assign w_srcBeats    = beatsOf(w_srcSize);
    assign w_srcLastIdx  = w_srcBeats[1:0] - 2'd1;
    assign w_nextIdx     = r_beatIdx + 2'd1;

    always_comb begin
        w_bankValidNext = r_bankValid;
        if (w_finalAccept) begin
            w_bankValidNext[r_rdPtr] = 1'b0;
        end
        if (w_loadAccept) begin
            w_bankValidNext[r_wrPtr] = 1'b1;
        end
    end

    always_comb begin
        w_countNext = r_count;
        case ({w_loadAccept, w_finalAccept})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_loadAccept && !stop_i) begin
            r_bankData[r_wrPtr] <= w_loadData;
            r_bankSize[r_wrPtr] <= size_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state         <= BUF_IDLE;
            r_bankValid     <= '0;
            r_wrPtr         <= '0;
            r_rdPtr         <= '0;
            r_count         <= '0;
            r_beatIdx       <= 2'd0;
            r_lastIdx       <= 2'd0;
            wr_valid_o      <= 1'b0;
            wr_data_o       <= '0;
            wr_last_o       <= 1'b0;
            wr_size_o       <= 4'd0;
            wr_word_count_o <= 8'd0;
            full_o          <= 1'b0;
            empty_o         <= 1'b1;
            size_err_o      <= 1'b0;
            ovf_err_o       <= 1'b0;
        end else if (stop_i) begin
            r_state         <= BUF_IDLE;
            r_bankValid     <= '0;
            r_wrPtr         <= '0;
            r_rdPtr         <= '0;
            r_count         <= '0;
            r_beatIdx       <= 2'd0;
            r_lastIdx       <= 2'd0;
            wr_valid_o      <= 1'b0;
            wr_last_o       <= 1'b0;
            wr_word_count_o <= 8'd0;
            full_o          <= 1'b0;
            empty_o         <= 1'b1;
            size_err_o      <= 1'b0;
            ovf_err_o       <= 1'b0;
        end else begin
            if (load_i && !w_loadLegal) begin
                size_err_o <= 1'b1;
            end
            if (w_loadOvf) begin
                ovf_err_o <= 1'b1;
            end
            if (w_loadAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_finalAccept) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_bankValid <= w_bankValidNext;
            r_count     <= w_countNext;
            full_o      <= (w_countNext == FULL_CNT);
            empty_o     <= (w_countNext == '0);

            case (r_state)
                BUF_IDLE: begin
                    if (w_srcValid) begin
                        wr_valid_o      <= 1'b1;
                        wr_data_o       <= w_srcData[BEAT_W-1:0];
                        wr_size_o       <= w_srcSize;
                        wr_word_count_o <= 8'd0;
                        r_beatIdx       <= 2'd0;
                        r_lastIdx       <= w_srcLastIdx;
                        if (w_srcBeats == 3'd1) begin
                            wr_last_o <= 1'b1;
                            r_state   <= BUF_LAST;
                        end else begin
                            wr_last_o <= 1'b0;
                            r_state   <= BUF_DRAIN;
                        end
                    end
                end
                BUF_DRAIN: begin
                    if (w_handshake) begin
                        wr_data_o       <= r_bankData[r_rdPtr][{w_nextIdx, 6'b0} +: BEAT_W];
                        wr_word_count_o <= {5'd0, w_nextIdx, 1'b0};
                        r_beatIdx       <= w_nextIdx;
                        if (w_nextIdx == r_lastIdx) begin
                            wr_last_o <= 1'b1;
                            r_state   <= BUF_LAST;
                        end
                    end
                end
                BUF_LAST: begin
                    // Always return through idle so bursts are separated by one bubble.
                    if (w_handshake) begin
                        wr_valid_o      <= 1'b0;
                        wr_last_o       <= 1'b0;
                        wr_word_count_o <= 8'd0;
                        r_state         <= BUF_IDLE;
                    end
                end
                default: begin
                    r_state <= BUF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_codma_wr_data_buffer.sv
// Table-driven bench for ip_codma_wr_data_buffer: burst drain, backpressure, overflow, size errors, stop/reset.
// Expected beats follow the CODMA_WRBUF_BSWAP_EN setting of the build.
module tb_ip_codma_wr_data_buffer;

    typedef struct {
        string        name;
        logic         load;
        logic [3:0]   size;
        logic [255:0] data;
        logic         ready;
        logic         stop;
        logic         expValid;
        logic [63:0]  expData;
        logic         expLast;
        logic [7:0]   expWc;
        logic [3:0]   expSize;
        logic         expFull;
        logic         expEmpty;
        logic         expSizeErr;
        logic         expOvfErr;
    } vec_t;

    logic         clk_i;
    logic         reset_n_i;
    logic         stop_i;
    logic         load_i;
    logic [3:0]   size_i;
    logic [255:0] data_i;
    logic [63:0]  wr_data_o;
    logic         wr_valid_o;
    logic         wr_ready_i;
    logic         wr_last_o;
    logic [3:0]   wr_size_o;
    logic [7:0]   wr_word_count_o;
    logic         full_o;
    logic         empty_o;
    logic         size_err_o;
    logic         ovf_err_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    ip_codma_wr_data_buffer #(.NUM_BANKS(2), .BEAT_W(64)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .stop_i          (stop_i),
        .load_i          (load_i),
        .size_i          (size_i),
        .data_i          (data_i),
        .wr_data_o       (wr_data_o),
        .wr_valid_o      (wr_valid_o),
        .wr_ready_i      (wr_ready_i),
        .wr_last_o       (wr_last_o),
        .wr_size_o       (wr_size_o),
        .wr_word_count_o (wr_word_count_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .size_err_o      (size_err_o),
        .ovf_err_o       (ovf_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mkData(input logic [31:0] base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            d[32*i +: 32] = base + 32'(i);
        end
        return d;
    endfunction

    // Expected beats are written unswapped; the byte-swap build reverses each 32-bit word.
    function automatic logic [63:0] swapIf(input logic [63:0] b);
        logic [63:0] r;
`ifdef CODMA_WRBUF_BSWAP_EN
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                r[32*w + 8*k +: 8] = b[32*w + 8*(3-k) +: 8];
            end
        end
`else
        r = b;
`endif
        return r;
    endfunction

    function automatic vec_t mk(input string name, input logic load, input logic [3:0] size,
                                input logic [255:0] data, input logic ready, input logic stop,
                                input logic eValid, input logic [63:0] eData, input logic eLast,
                                input logic [7:0] eWc, input logic [3:0] eSize, input logic eFull,
                                input logic eEmpty, input logic eSErr, input logic eOErr);
        vec_t v;
        v.name = name; v.load = load; v.size = size; v.data = data; v.ready = ready; v.stop = stop;
        v.expValid = eValid; v.expData = eData; v.expLast = eLast; v.expWc = eWc; v.expSize = eSize;
        v.expFull = eFull; v.expEmpty = eEmpty; v.expSizeErr = eSErr; v.expOvfErr = eOErr;
        return v;
    endfunction

    task automatic checkField(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk_i);
        load_i     = v.load;
        size_i     = v.size;
        data_i     = v.data;
        wr_ready_i = v.ready;
        stop_i     = v.stop;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField({v.name, ".valid"}, 64'(wr_valid_o), 64'(v.expValid));
        checkField({v.name, ".last"}, 64'(wr_last_o), 64'(v.expLast));
        checkField({v.name, ".wc"}, 64'(wr_word_count_o), 64'(v.expWc));
        checkField({v.name, ".full"}, 64'(full_o), 64'(v.expFull));
        checkField({v.name, ".empty"}, 64'(empty_o), 64'(v.expEmpty));
        checkField({v.name, ".sizeErr"}, 64'(size_err_o), 64'(v.expSizeErr));
        checkField({v.name, ".ovfErr"}, 64'(ovf_err_o), 64'(v.expOvfErr));
        if (v.expValid) begin
            checkField({v.name, ".data"}, wr_data_o, swapIf(v.expData));
            checkField({v.name, ".size"}, 64'(wr_size_o), 64'(v.expSize));
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge clk_i);
        #1;
        checkOutput(v);
    endtask

    task automatic checkResetValues(input string tag);
        checkField({tag, ".valid"}, 64'(wr_valid_o), 64'd0);
        checkField({tag, ".last"}, 64'(wr_last_o), 64'd0);
        checkField({tag, ".data"}, wr_data_o, 64'd0);
        checkField({tag, ".size"}, 64'(wr_size_o), 64'd0);
        checkField({tag, ".wc"}, 64'(wr_word_count_o), 64'd0);
        checkField({tag, ".empty"}, 64'(empty_o), 64'd1);
        checkField({tag, ".full"}, 64'(full_o), 64'd0);
        checkField({tag, ".sizeErr"}, 64'(size_err_o), 64'd0);
        checkField({tag, ".ovfErr"}, 64'(ovf_err_o), 64'd0);
    endtask

    initial begin
        logic [255:0] z;
        logic [255:0] bsw;
        z = '0;
        bsw = '0;
        bsw[31:0]  = 32'h11223344;
        bsw[63:32] = 32'hAABBCCDD;

        // name, load, size, data, ready, stop | valid, data, last, wc, size, full, empty, sErr, oErr
        vecs.push_back(mk("b4_beat0", 1, 9, mkData(32'h00), 1, 0, 1, 64'h00000001_00000000, 0, 0, 9, 0, 0, 0, 0));
        vecs.push_back(mk("b4_beat1", 0, 0, z, 1, 0, 1, 64'h00000003_00000002, 0, 2, 9, 0, 0, 0, 0));
        vecs.push_back(mk("b4_beat2", 0, 0, z, 1, 0, 1, 64'h00000005_00000004, 0, 4, 9, 0, 0, 0, 0));
        vecs.push_back(mk("b4_beat3", 0, 0, z, 1, 0, 1, 64'h00000007_00000006, 1, 6, 9, 0, 0, 0, 0));
        vecs.push_back(mk("b4_done",  0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));

        vecs.push_back(mk("bp_load",   1, 8, mkData(32'h10), 0, 0, 1, 64'h00000011_00000010, 0, 0, 8, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk($sformatf("bp_stall%0d", i), 0, 0, z, 0, 0, 1, 64'h00000011_00000010, 0, 0, 8, 0, 0, 0, 0));
        end
        vecs.push_back(mk("bp_beat1",  0, 0, z, 1, 0, 1, 64'h00000013_00000012, 1, 2, 8, 0, 0, 0, 0));
        vecs.push_back(mk("bp_done",   0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));

        vecs.push_back(mk("ov_load1",  1, 9, mkData(32'h20), 0, 0, 1, 64'h00000021_00000020, 0, 0, 9, 0, 0, 0, 0));
        vecs.push_back(mk("ov_load2",  1, 8, mkData(32'h30), 0, 0, 1, 64'h00000021_00000020, 0, 0, 9, 1, 0, 0, 0));
        vecs.push_back(mk("ov_drop",   1, 3, mkData(32'h40), 0, 0, 1, 64'h00000021_00000020, 0, 0, 9, 1, 0, 0, 1));
        vecs.push_back(mk("ov_beat1",  0, 0, z, 1, 0, 1, 64'h00000023_00000022, 0, 2, 9, 1, 0, 0, 1));
        vecs.push_back(mk("ov_beat2",  0, 0, z, 1, 0, 1, 64'h00000025_00000024, 0, 4, 9, 1, 0, 0, 1));
        vecs.push_back(mk("ov_beat3",  0, 0, z, 1, 0, 1, 64'h00000027_00000026, 1, 6, 9, 1, 0, 0, 1));
        vecs.push_back(mk("ov_hold",   0, 0, z, 0, 0, 1, 64'h00000027_00000026, 1, 6, 9, 1, 0, 0, 1));
        vecs.push_back(mk("ov_swap",   1, 3, mkData(32'h50), 1, 0, 0, 64'h0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("ov_b1beat0", 0, 0, z, 1, 0, 1, 64'h00000031_00000030, 0, 0, 8, 1, 0, 0, 1));
        vecs.push_back(mk("ov_b1beat1", 0, 0, z, 1, 0, 1, 64'h00000033_00000032, 1, 2, 8, 1, 0, 0, 1));
        vecs.push_back(mk("ov_b1done",  0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ov_b0single", 0, 0, z, 1, 0, 1, 64'h00000051_00000050, 1, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk("ov_b0done",  0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("stop_clr",   0, 0, z, 1, 1, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));

        vecs.push_back(mk("bad_size",   1, 5, mkData(32'h90), 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("bad_idle",   0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 1, 0));

        vecs.push_back(mk("st_beat0",  1, 9, mkData(32'h60), 1, 0, 1, 64'h00000061_00000060, 0, 0, 9, 0, 0, 1, 0));
        vecs.push_back(mk("st_beat1",  0, 0, z, 1, 0, 1, 64'h00000063_00000062, 0, 2, 9, 0, 0, 1, 0));
        vecs.push_back(mk("st_stop",   0, 0, z, 1, 1, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("st_after",  0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("st_prio",   1, 9, mkData(32'h80), 1, 1, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("st_after2", 0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));

        reset_n_i  = 1'b0;
        stop_i     = 1'b0;
        load_i     = 1'b0;
        size_i     = 4'd0;
        data_i     = '0;
        wr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkResetValues("reset");
        reset_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

        // Asynchronous reset in the middle of a burst, with a sticky error pending.
        runVec(mk("rst_badsize", 1, 5, z, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 1, 0));
        runVec(mk("rst_beat0", 1, 9, mkData(32'h70), 0, 0, 1, 64'h00000071_00000070, 0, 0, 9, 0, 0, 1, 0));
        #2;
        reset_n_i = 1'b0;
        #1;
        checkResetValues("rst_mid");
        @(negedge clk_i);
        load_i    = 1'b0;
        reset_n_i = 1'b1;

        runVec(mk("sz3_beat", 1, 3, bsw, 0, 0, 1, 64'hAABBCCDD_11223344, 1, 0, 3, 0, 0, 0, 0));
        runVec(mk("sz3_done", 0, 0, z, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
